// File: rtl/dram_lsu_pkg.sv
// Shared constants for the byte-serial load/store sequencer: size codes,
// FSM states and the fixed dram byte-mode select.
package dram_lsu_pkg;

    localparam int DW = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] MEM_SEL_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Number of byte accesses a request of the given size needs.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dram_lsu_extend.sv
// Load-data extension: right-aligned assembled bytes (first byte most
// significant) plus size/unsigned flag -> 32-bit response data.
module dram_lsu_extend
    import dram_lsu_pkg::*;
(
    input  logic [DW-1:0] asm_data,
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    output logic [DW-1:0] rdata
);

    logic fill_byte;
    logic fill_half;

    assign fill_byte = !is_unsigned && asm_data[7];
    assign fill_half = !is_unsigned && asm_data[15];

    always_comb begin
        rdata = '0;
        case (size)
            SZ_BYTE: rdata = {{24{fill_byte}}, asm_data[7:0]};
            SZ_HALF: rdata = {{16{fill_half}}, asm_data[15:0]};
            SZ_WORD: rdata = asm_data;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dram_lsu_seq.sv
// Byte-serial big-endian load/store sequencer in front of the byte-wide dram.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests are rejected with RSP_ERR.
module dram_lsu_seq
    import dram_lsu_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [1:0]    REQ_SIZE,
    input  logic          REQ_UNSIGNED,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [31:0]   REQ_WDATA,
    output logic          RSP_VALID,
    output logic [31:0]   RSP_RDATA,
    output logic          RSP_ERR,
    output logic [AW-1:0] MEM_ADDR,
    output logic [1:0]    MEM_SEL,
    output logic          MEM_MW,
    output logic [7:0]    MEM_WDATA,
    input  logic [7:0]    MEM_RBYTE
);

    state_t        state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic [AW-1:0] addr_reg;
    logic [1:0]    size_reg;
    logic          uns_reg;
    logic          we_reg;
    logic          err_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   asm_reg;

    logic          accept;
    logic          req_err;
    logic [31:0]   wdata_aligned;
    logic [2:0]    nbytes;
    logic [31:0]   ext_data;

    assign REQ_READY = (state_reg == IDLE) && !RST;
    assign accept    = REQ_VALID && REQ_READY;
    assign nbytes    = size_bytes(size_reg);

    always_comb begin
        req_err = (REQ_SIZE == SZ_RSVD);
`ifdef MISALIGN_TRAP_EN
        if ((REQ_SIZE == SZ_HALF) && REQ_ADDR[0])
            req_err = 1'b1;
        if ((REQ_SIZE == SZ_WORD) && (REQ_ADDR[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Store data is left-aligned so the next outgoing byte is always [31:24].
    always_comb begin
        wdata_aligned = REQ_WDATA;
        case (REQ_SIZE)
            SZ_BYTE: wdata_aligned = {REQ_WDATA[7:0], 24'h000000};
            SZ_HALF: wdata_aligned = {REQ_WDATA[15:0], 16'h0000};
            default: wdata_aligned = REQ_WDATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // READ runs one cycle longer than WRITE: the last byte issued in cycle N
    // only arrives from the registered dram read in cycle N+1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next = '0;
                    if (req_err)
                        state_next = RESP;
                    else if (REQ_WE)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                if (cnt_reg == nbytes)
                    state_next = RESP;
                else
                    cnt_next = cnt_reg + 3'd1;
            end
            WRITE: begin
                if (cnt_reg == nbytes - 3'd1)
                    state_next = RESP;
                else
                    cnt_next = cnt_reg + 3'd1;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_reg  <= '0;
            size_reg  <= SZ_BYTE;
            uns_reg   <= 1'b0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            wdata_reg <= '0;
            asm_reg   <= '0;
        end else if (accept) begin
            addr_reg  <= REQ_ADDR;
            size_reg  <= REQ_SIZE;
            uns_reg   <= REQ_UNSIGNED;
            we_reg    <= REQ_WE;
            err_reg   <= req_err;
            wdata_reg <= wdata_aligned;
            asm_reg   <= '0;
        end else begin
            if ((state_reg == READ) && (cnt_reg != 3'd0))
                asm_reg <= {asm_reg[23:0], MEM_RBYTE};
            if (state_reg == WRITE)
                wdata_reg <= {wdata_reg[23:0], 8'h00};
        end
    end

    dram_lsu_extend u_extend (
        .asm_data    (asm_reg),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .rdata       (ext_data)
    );

    // Memory-side outputs decode straight from the async-reset state, so the
    // write strobe falls the instant RST rises.
    assign MEM_SEL   = MEM_SEL_BYTE;
    assign MEM_MW    = (state_reg == WRITE);
    assign MEM_ADDR  = ((state_reg == READ) || (state_reg == WRITE)) ?
                       (addr_reg + AW'(cnt_reg)) : '0;
    assign MEM_WDATA = (state_reg == WRITE) ? wdata_reg[31:24] : 8'h00;

    assign RSP_VALID = (state_reg == RESP);
    assign RSP_ERR   = RSP_VALID && err_reg;
    assign RSP_RDATA = (RSP_VALID && !we_reg && !err_reg) ? ext_data : 32'h0;

endmodule
